// File: rtl/pc_fetch_unit.sv
// IF-stage PC owner: issues req/ack instruction fetches, presents IF/ID outputs,
// honours the MIPS branch delay slot and absorbs hazard stalls with a one-entry skid.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pcadd4,
  output logic        addr_err,
  output logic        fetch_timeout
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_FETCH, S_FULL, S_KILL} state_e;

  state_e             state_q, state_d;
  logic               started_q;
  logic [31:0]        pc_q, pc_d;
  logic               if_valid_q, if_valid_d;
  logic [31:0]        if_instr_q, if_instr_d;
  logic [31:0]        if_pc_q, if_pc_d;
  logic [31:0]        if_pcadd4_q, if_pcadd4_d;
  logic [31:0]        skid_instr_q, skid_instr_d;
  logic [31:0]        skid_pc_q, skid_pc_d;
  logic               pend_q, pend_d;
  logic [31:0]        tgt_q, tgt_d;
  logic               addr_err_q, addr_err_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic               ack;
  logic               take_mem;
  logic               take_skid;
  logic [31:0]        tgt;
  logic [31:0]        next_pc;

  // No request in the first cycle after reset release, nor while the skid is full.
  assign im_req        = started_q && (state_q != S_FULL);
  assign im_addr       = pc_q;
  assign if_valid      = if_valid_q;
  assign if_instr      = if_instr_q;
  assign if_pc         = if_pc_q;
  assign if_pcadd4     = if_pcadd4_q;
  assign addr_err      = addr_err_q;
  assign fetch_timeout = timeout_q;

  // NOTE: every variable gets its default with a blocking assignment first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    if_pcadd4_d  = if_pcadd4_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    pend_d       = pend_q;
    tgt_d        = tgt_q;
    addr_err_d   = addr_err_q;
    timeout_d    = timeout_q;
    wait_cnt_d   = wait_cnt_q;
    take_mem     = 1'b0;
    take_skid    = 1'b0;

    ack     = im_req && im_ack;
    tgt     = {redir_target[31:2], 2'b00};
    next_pc = pend_q ? tgt_q : pc_q + 32'd4;

    if (!stall) if_valid_d = 1'b0;
    if (redir_valid && (redir_target[1:0] != 2'b00)) addr_err_d = 1'b1;

    case (state_q)
      S_FETCH: begin
        // if_pcadd4_q is the delay-slot PC of the branch currently in ID.
        if (redir_valid && (pc_q == if_pcadd4_q)) begin
          if (ack) begin
            take_mem = 1'b1;
            pc_d     = tgt;
            pend_d   = 1'b0;
          end else begin
            pend_d = 1'b1;
            tgt_d  = tgt;
          end
        end else if (redir_valid) begin
          if (ack) begin
            pc_d = tgt;
          end else begin
            tgt_d   = tgt;
            state_d = S_KILL;
          end
        end else if (ack) begin
          pc_d   = next_pc;
          pend_d = 1'b0;
          if (stall && if_valid_q) begin
            skid_instr_d = im_rdata;
            skid_pc_d    = pc_q;
            state_d      = S_FULL;
          end else begin
            take_mem = 1'b1;
          end
        end
      end
      S_FULL: begin
        if (!stall) begin
          take_skid = 1'b1;
          state_d   = S_FETCH;
          if (redir_valid) pc_d = tgt;
        end
      end
      S_KILL: begin
        if (ack) begin
          pc_d    = tgt_q;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    if (take_mem) begin
      if_valid_d  = 1'b1;
      if_instr_d  = im_rdata;
      if_pc_d     = pc_q;
      if_pcadd4_d = pc_q + 32'd4;
    end else if (take_skid) begin
      if_valid_d  = 1'b1;
      if_instr_d  = skid_instr_q;
      if_pc_d     = skid_pc_q;
      if_pcadd4_d = skid_pc_q + 32'd4;
    end

    if (ack) begin
      wait_cnt_d = '0;
    end else if (im_req) begin
      if (wait_cnt_q != CNT_W'(TIMEOUT)) wait_cnt_d = wait_cnt_q + CNT_W'(1);
      if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) timeout_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: skid and target data are reset as well; they are only a few flops and keep X out of the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      started_q    <= 1'b0;
      pc_q         <= RESET_PC;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      if_pcadd4_q  <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      pend_q       <= 1'b0;
      tgt_q        <= '0;
      addr_err_q   <= 1'b0;
      timeout_q    <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      started_q    <= 1'b1;
      pc_q         <= pc_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      if_pcadd4_q  <= if_pcadd4_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      pend_q       <= pend_d;
      tgt_q        <= tgt_d;
      addr_err_q   <= addr_err_d;
      timeout_q    <= timeout_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: per-cycle vector table plus hand-written
// timeout and asynchronous-reset sequences.
module tb_pc_fetch_unit;

  localparam logic [31:0] MAGIC = 32'hA5C3_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_target = '0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack = 1'b0;
  logic [31:0] im_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pcadd4;
  logic        addr_err;
  logic        fetch_timeout;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit          rst;
    bit          stall;
    bit          rv;
    logic [31:0] rt;
    bit          ack;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_val;
    logic [31:0] e_pc;
    bit          e_aerr;
    bit          e_tmo;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  // Instruction memory returns a word derived from the requested address.
  assign im_rdata = im_addr ^ MAGIC;

  pc_fetch_unit #(.RESET_PC(32'h0000_3000), .TIMEOUT(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .redir_valid   (redir_valid),
    .redir_target  (redir_target),
    .im_req        (im_req),
    .im_addr       (im_addr),
    .im_ack        (im_ack),
    .im_rdata      (im_rdata),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_pcadd4     (if_pcadd4),
    .addr_err      (addr_err),
    .fetch_timeout (fetch_timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input bit rst, input bit stl, input bit rv, input logic [31:0] rt,
                             input bit ack, input bit e_req, input logic [31:0] e_addr,
                             input bit e_val, input logic [31:0] e_pc,
                             input bit e_aerr, input bit e_tmo);
    vec_t t;
    t.rst = rst; t.stall = stl; t.rv = rv; t.rt = rt; t.ack = ack;
    t.e_req = e_req; t.e_addr = e_addr; t.e_val = e_val; t.e_pc = e_pc;
    t.e_aerr = e_aerr; t.e_tmo = e_tmo;
    return t;
  endfunction

  // Reset, fetch 0x3000/0x3004, then ack 0x3008 under stall so it lands in the skid.
  task automatic push_skid_prefix();
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0,            0, 0,            0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 1, 32'h0000_3000, 0, 0,            0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 1, 32'h0000_3004, 1, 32'h0000_3000, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 1, 1, 32'h0000_3008, 1, 32'h0000_3004, 0, 0));
  endtask

  task automatic apply_reset();
    rst_n        = 1'b0;
    stall        = 1'b0;
    redir_valid  = 1'b0;
    redir_target = '0;
    im_ack       = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    if (t.rst) apply_reset();
    @(negedge clk);
    stall        = t.stall;
    redir_valid  = t.rv;
    redir_target = t.rt;
    im_ack       = t.ack;
    #1;
    check($sformatf("v%0d im_req", idx), {31'd0, im_req}, {31'd0, t.e_req});
    if (t.e_req) check($sformatf("v%0d im_addr", idx), im_addr, t.e_addr);
    check($sformatf("v%0d if_valid", idx), {31'd0, if_valid}, {31'd0, t.e_val});
    if (t.e_val) begin
      check($sformatf("v%0d if_pc", idx), if_pc, t.e_pc);
      check($sformatf("v%0d if_instr", idx), if_instr, t.e_pc ^ MAGIC);
      check($sformatf("v%0d if_pcadd4", idx), if_pcadd4, t.e_pc + 32'd4);
    end
    check($sformatf("v%0d addr_err", idx), {31'd0, addr_err}, {31'd0, t.e_aerr});
    check($sformatf("v%0d fetch_timeout", idx), {31'd0, fetch_timeout}, {31'd0, t.e_tmo});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Straight-line fetch, then stall on 0x3008 and drain the skid.
    push_skid_prefix();
    vecs.push_back(v(0, 1, 0, 0, 0, 0, 0,            1, 32'h0000_3004, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0,            1, 32'h0000_3004, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 1, 32'h0000_300C, 1, 32'h0000_3008, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 32'h0000_3010, 1, 32'h0000_300C, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 32'h0000_3010, 0, 0,            0, 0));

    // Branch at 0x3004 redirects while its delay slot 0x3008 is still pending.
    vecs.push_back(v(1, 0, 0, 0,             0, 0, 0,            0, 0,            0, 0));
    vecs.push_back(v(0, 0, 0, 0,             1, 1, 32'h0000_3000, 0, 0,            0, 0));
    vecs.push_back(v(0, 0, 0, 0,             1, 1, 32'h0000_3004, 1, 32'h0000_3000, 0, 0));
    vecs.push_back(v(0, 0, 1, 32'h0000_3100, 0, 1, 32'h0000_3008, 1, 32'h0000_3004, 0, 0));
    vecs.push_back(v(0, 0, 0, 0,             1, 1, 32'h0000_3008, 0, 0,            0, 0));
    vecs.push_back(v(0, 0, 0, 0,             1, 1, 32'h0000_3100, 1, 32'h0000_3008, 0, 0));
    vecs.push_back(v(0, 0, 0, 0,             0, 1, 32'h0000_3104, 1, 32'h0000_3100, 0, 0));

    // Redirect out of the full skid, then a redirect with the next fetch in flight -> KILL.
    push_skid_prefix();
    vecs.push_back(v(0, 0, 1, 32'h0000_3010, 0, 0, 0,            1, 32'h0000_3004, 0, 0));
    vecs.push_back(v(0, 0, 1, 32'h0000_3100, 0, 1, 32'h0000_3010, 1, 32'h0000_3008, 0, 0));
    vecs.push_back(v(0, 0, 0, 0,             1, 1, 32'h0000_3010, 0, 0,            0, 0));
    vecs.push_back(v(0, 0, 0, 0,             1, 1, 32'h0000_3100, 0, 0,            0, 0));
    vecs.push_back(v(0, 0, 0, 0,             0, 1, 32'h0000_3104, 1, 32'h0000_3100, 0, 0));

    // Redirect coinciding with the ack (data discarded) and a misaligned target.
    push_skid_prefix();
    vecs.push_back(v(0, 0, 1, 32'h0000_3010, 0, 0, 0,            1, 32'h0000_3004, 0, 0));
    vecs.push_back(v(0, 0, 1, 32'h0000_3102, 1, 1, 32'h0000_3010, 1, 32'h0000_3008, 0, 0));
    vecs.push_back(v(0, 0, 0, 0,             1, 1, 32'h0000_3100, 0, 0,            1, 0));
    vecs.push_back(v(0, 0, 0, 0,             0, 1, 32'h0000_3104, 1, 32'h0000_3100, 1, 0));

    // PC wraparound from 0xFFFF_FFFC to 0; reset also clears the sticky addr_err.
    push_skid_prefix();
    vecs.push_back(v(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0,            1, 32'h0000_3004, 0, 0));
    vecs.push_back(v(0, 0, 0, 0,             1, 1, 32'hFFFF_FFFC, 1, 32'h0000_3008, 0, 0));
    vecs.push_back(v(0, 0, 0, 0,             0, 1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 0, 0));

    // Ack three cycles late: request held, bubbles, no timeout.
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0,            0, 0,            0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 32'h0000_3000, 0, 0,            0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 32'h0000_3000, 0, 0,            0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 32'h0000_3000, 0, 0,            0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 1, 32'h0000_3000, 0, 0,            0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 1, 32'h0000_3004, 1, 32'h0000_3000, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 32'h0000_3008, 1, 32'h0000_3004, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 32'h0000_3008, 0, 0,            0, 0));

    foreach (vecs[i]) run_vec(vecs[i], i);

    // 0x3008 has waited one cycle so far; 14 more makes 15, one short of TIMEOUT.
    for (int i = 0; i < 14; i++) @(negedge clk);
    #1;
    check("tmo 15 waits", {31'd0, fetch_timeout}, 32'd0);
    check("tmo req held", {31'd0, im_req}, 32'd1);
    check("tmo addr held", im_addr, 32'h0000_3008);
    @(negedge clk);
    #1;
    check("tmo 16 waits", {31'd0, fetch_timeout}, 32'd1);
    check("tmo req still", {31'd0, im_req}, 32'd1);

    // Reset asserted mid-request takes effect without a clock edge.
    rst_n = 1'b0;
    #1;
    check("async rst im_req", {31'd0, im_req}, 32'd0);
    check("async rst if_valid", {31'd0, if_valid}, 32'd0);
    check("async rst timeout", {31'd0, fetch_timeout}, 32'd0);
    check("async rst if_pc", if_pc, 32'd0);
    check("async rst if_pcadd4", if_pcadd4, 32'd0);
    check("async rst im_addr", im_addr, 32'h0000_3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
